// File: rtl/dcache_assoc_ctrl.sv
// rtl/dcache_assoc_ctrl.sv - N-way set-associative write-back/write-allocate data cache controller
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_assoc_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WSEL_W = OFF_W - 2;
  localparam int BSEL_W = $clog2(LINE_W);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WB, ST_ALLOC, ST_FILL} state_t;

  state_t            state_q;
  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [WAY_W-1:0]  victim_q;

  logic [TAG_W-1:0]  tag_in;
  logic [IDX_W-1:0]  idx_in;
  logic [WSEL_W-1:0] wsel;
  logic [BSEL_W-1:0] bit_lsb;
  logic              req;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              found_inv;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] wr_line;
  logic              wr_hit;
  logic              stall;
  logic              alloc_done;
  logic              unused_addr_lsb;

  assign tag_in          = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign idx_in          = p1_addr_i[OFF_W +: IDX_W];
  assign wsel            = p1_addr_i[2 +: WSEL_W];
  assign bit_lsb         = {wsel, {$clog2(DATA_W){1'b0}}};
  assign req             = p1_MemRead_i | p1_MemWrite_i;
  assign unused_addr_lsb = ^p1_addr_i[1:0];
  assign alloc_done      = (state_q == ST_ALLOC) && mem_ack_i;

  // At most one way can match, so the last match wins without priority concerns.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx_in] && (tag_q[w][idx_in] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    found_inv = 1'b0;
    victim    = (WAYS == 1) ? '0 : rr_q[idx_in];
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[w][idx_in]) begin
        found_inv = 1'b1;
        victim    = WAY_W'(w);
      end
    end
  end

  always_comb begin
    hit_line                     = data_q[hit_way][idx_in];
    p1_data_o                    = hit ? hit_line[bit_lsb +: DATA_W] : '0;
    wr_line                      = hit_line;
    wr_line[bit_lsb +: DATA_W]   = p1_data_i;
  end

  // The FILL cycle re-runs the lookup, so a pending store completes there too.
  assign wr_hit = ((state_q == ST_IDLE) || (state_q == ST_FILL)) && hit && p1_MemWrite_i;

  always_comb begin
    case (state_q)
      ST_IDLE: stall = req && !hit;
      ST_FILL: stall = req && !hit;
      default: stall = 1'b1;
    endcase
    p1_stall_o = rst_i & stall;
  end

  always_ff @(posedge clk_i) begin
    if (alloc_done) begin
      data_q[victim_q][idx_in] <= mem_data_i;
      tag_q[victim_q][idx_in]  <= tag_in;
    end else if (wr_hit) begin
      data_q[hit_way][idx_in] <= wr_line;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      victim_q     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      if (wr_hit) begin
        dirty_q[hit_way][idx_in] <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (req && !hit) begin
            victim_q     <= victim;
            mem_enable_o <= 1'b1;
            if (valid_q[victim][idx_in] && dirty_q[victim][idx_in]) begin
              state_q     <= ST_WB;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_q[victim][idx_in], idx_in, {OFF_W{1'b0}}};
              mem_data_o  <= data_q[victim][idx_in];
            end else begin
              state_q     <= ST_ALLOC;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {tag_in, idx_in, {OFF_W{1'b0}}};
              mem_data_o  <= '0;
            end
          end
        end
        ST_WB: begin
          if (mem_ack_i) begin
            state_q     <= ST_ALLOC;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag_in, idx_in, {OFF_W{1'b0}}};
            mem_data_o  <= '0;
          end
        end
        ST_ALLOC: begin
          if (mem_ack_i) begin
            state_q                   <= ST_FILL;
            mem_enable_o              <= 1'b0;
            mem_addr_o                <= '0;
            valid_q[victim_q][idx_in] <= 1'b1;
            dirty_q[victim_q][idx_in] <= 1'b0;
            rr_q[idx_in] <= (rr_q[idx_in] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_in] + WAY_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic hit_evt;
  logic miss_evt;

  assign hit_evt  = (state_q == ST_IDLE) && req && hit;
  assign miss_evt = (state_q == ST_IDLE) && req && !hit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_evt && (hit_cnt_o != 32'hFFFF_FFFF)) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (miss_evt && (miss_cnt_o != 32'hFFFF_FFFF)) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
